axi4_rd_to_ahb_bridge: RTL and testbench
========================================

Name: axi4_rd_to_ahb_bridge

Overview:
- Parametrised AXI4 read-only slave to AHB-Lite master bridge for display/frame-buffer fetch paths; successor to the single-beat VGA read bridge.
- Adds pipelined AHB address/data phases, AXI R-channel backpressure via an internal response FIFO, and INCR/FIXED/WRAP burst support with narrow transfers.
- Adds AHB error mapping, 1KB-boundary handling and ID echo.
- Sits between the display-controller AXI read master and the AHB memory fabric.

Parameters:
- ADDR_W, 32, address width of AXI and AHB.
- DATA_W, 64, data width (32/64/128).
- ID_W, 4, AXI ID width.
- FIFO_DEPTH, 4, R-channel response FIFO entries (power of two, >=2).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- arid  in  ID_W  read ID
- araddr  in  ADDR_W  start address
- arlen  in  8  beats-1
- arsize  in  3  log2 bytes per beat
- arburst  in  2  00 FIXED, 01 INCR, 10 WRAP
- arvalid  in  1  AR valid
- arready  out  1  AR ready
- rid  out  ID_W  echoed arid
- rdata  out  DATA_W  read data
- rresp  out  2  00 OKAY, 10 SLVERR
- rvalid  out  1  R valid
- rready  in  1  R ready
- rlast  out  1  last beat
- ahb_haddr  out  ADDR_W  AHB address
- ahb_hburst  out  3  001 INCR, 000 SINGLE (FIXED)
- ahb_hprot  out  4  constant 4'b0011
- ahb_hsize  out  3  latched arsize
- ahb_htrans  out  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- ahb_hwrite  out  1  constant 0
- ahb_hwdata  out  DATA_W  constant 0
- ahb_hrdata  in  DATA_W  read data
- ahb_hready  in  1  transfer ready
- ahb_hresp  in  1  error response

Behaviour:
- Reset: single clock domain. Synchronous active-high reset on clk. During and after rst, outputs are: state IDLE, arready=1, rvalid=0, rlast=0, rresp=0, rid=0, htrans=IDLE, haddr=0. FIFO is flushed and all counters cleared.
- Reset mid-burst: the transaction is abandoned with no further R beats. The AHB bus goes to IDLE on the next cycle.
- AR channel: arready=1 only in IDLE. On handshake, latch arid, araddr, arlen, arsize and arburst.
- Oversize request: if arsize > log2(DATA_W/8), issue no AHB traffic and return arlen+1 beats with rresp=10 and rdata=0.
- State ADDR_ONLY: first address phase. htrans=NONSEQ.
- State PIPE: address of beat n+1 overlaps the data phase of beat n.
- State DATA_ONLY: final data phase. htrans=IDLE.
- State ERR: AHB error handling.
- Return to IDLE: after the last beat is pushed into the FIFO and the FIFO has drained the rlast beat.
- Address increment: 1<<arsize.
  - INCR: linear increment.
  - WRAP: wrap within (arlen+1)<<arsize bytes, aligned down.
  - FIXED: address is constant, every beat is NONSEQ, hburst=SINGLE.
  - INCR/WRAP: htrans=SEQ, except NONSEQ on the first beat, on a wrap point, and when the new address crosses a 1KB boundary (haddr[9:0]==0).
- Credit flow control: an address phase is issued only if fifo_count + beats_in_flight < FIFO_DEPTH. Otherwise drive BUSY mid-burst, or hold NONSEQ-pending with htrans=IDLE before the first beat. Address and control are held stable while hready=0.
- Data capture: each completed data phase (hready=1, hresp=0) pushes {hrdata, 00, last} into the FIFO. The FIFO drives the R channel. A beat pops on rvalid&rready. rdata, rresp and rlast stay stable while rvalid=1 and rready=0.
- AHB error: on hresp=1 with hready=0, the next cycle htrans=IDLE, cancelling any pipelined address.
  - On hresp=1 with hready=1, push that beat with rresp=10 and rdata=0.
  - Every remaining beat is returned as SLVERR with no further AHB transfers.
- Beat counter: 8-bit. rlast is asserted on beat arlen, i.e. exactly arlen+1 beats.
- arlen=0: a single NONSEQ transfer, then DATA_ONLY.
- FIFO: never overflows, by the credit rule. Pushing to and popping from a full FIFO in the same cycle is legal.

Test Plan:
- INCR, araddr=0x1000, arlen=3, arsize=3, rready=1, hready=1 -> haddr 0x1000/08/10/18, htrans NONSEQ,SEQ,SEQ,SEQ; 4 R beats OKAY, rlast on beat 4, rid=arid; first rvalid 2 cycles after the first NONSEQ.
- WRAP, araddr=0x2018, arlen=3, arsize=3 -> haddr 0x2018, 0x2000 (NONSEQ), 0x2008, 0x2010.
- INCR, araddr=0x13F8, arlen=1 -> 0x13F8 NONSEQ, 0x1400 NONSEQ (1KB crossing).
- rready=0 for 10 cycles during arlen=7 -> at most FIFO_DEPTH beats issued, then htrans=BUSY; no data lost, all 8 beats in order after rready=1.
- hresp error on beat 2 of arlen=3 -> beats 1 OKAY, 2-4 SLVERR, no AHB transfer after the error, rlast on beat 4.
- rst asserted mid-burst -> the next cycle shows htrans=IDLE, rvalid=0, arready=1; a new burst then completes normally.

Source files
------------

// File: rtl/axi4_rd_to_ahb_bridge.sv
// AXI4 read-only slave to AHB-Lite master bridge for frame-buffer fetch.
// Converts one AXI read burst at a time into pipelined AHB read transfers.
// Returned beats go through a small response FIFO, so the AXI R channel
// can apply backpressure without stalling the AHB data phase.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   ar*                   AXI read address channel (slave side)
//   r*                    AXI read data channel (slave side)
//   ahb_h*                AHB-Lite master (read only: hwrite/hwdata tied off)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | arready high, waiting for an AR handshake
// ADDR_ONLY | address phase with no data phase outstanding
// PIPE      | address of beat n+1 overlaps the data phase of beat n
// DATA_ONLY | data phase of the final beat, bus address phase is IDLE
// ERR       | error seen (or oversize request): remaining beats -> SLVERR
// DRAIN     | every beat queued, waiting for the FIFO to empty
module axi4_rd_to_ahb_bridge #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 64,
  parameter int ID_W       = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   arid,
  input  logic [ADDR_W-1:0] araddr,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic              arvalid,
  output logic              arready,
  output logic [ID_W-1:0]   rid,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rvalid,
  input  logic              rready,
  output logic              rlast,
  output logic [ADDR_W-1:0] ahb_haddr,
  output logic [2:0]        ahb_hburst,
  output logic [3:0]        ahb_hprot,
  output logic [2:0]        ahb_hsize,
  output logic [1:0]        ahb_htrans,
  output logic              ahb_hwrite,
  output logic [DATA_W-1:0] ahb_hwdata,
  input  logic [DATA_W-1:0] ahb_hrdata,
  input  logic              ahb_hready,
  input  logic              ahb_hresp
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int FW = DATA_W + 3;
  localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_W / 8));

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_BUSY   = 2'b01;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_ONLY, S_PIPE, S_DATA_ONLY, S_ERR, S_DRAIN
  } state_t;

  state_t            state_q, next_state;
  logic [ID_W-1:0]   id_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        len_q;
  logic [2:0]        size_q;
  logic [1:0]        burst_q;
  logic [7:0]        iss_cnt;
  logic [7:0]        push_cnt;
  logic              dphase_q;
  logic              nonseq_q;

  logic [FW-1:0]     fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     fifo_cnt;
  logic [FW-1:0]     head;

  logic              acc, push, push_err, pop, credit, fifo_full, addr_last;
  logic [CW:0]       credit_sum;
  logic [FW-1:0]     push_word;
  logic [ADDR_W-1:0] incr_bytes, lin_addr, wrap_mask, wrap_addr, next_addr;
  logic              next_nonseq;

  // Next beat address; a wrap point or a 1KB crossing restarts with NONSEQ.
  always_comb begin
    incr_bytes  = ADDR_W'(1) << size_q;
    lin_addr    = addr_q + incr_bytes;
    wrap_mask   = ((ADDR_W'(len_q) + ADDR_W'(1)) << size_q) - ADDR_W'(1);
    wrap_addr   = (addr_q & ~wrap_mask) | (lin_addr & wrap_mask);
    next_addr   = lin_addr;
    next_nonseq = (lin_addr[9:0] == 10'd0);
    case (burst_q)
      2'b00: begin
        next_addr   = addr_q;
        next_nonseq = 1'b1;
      end
      2'b10: begin
        next_addr   = wrap_addr;
        next_nonseq = ((lin_addr & wrap_mask) == '0) || (wrap_addr[9:0] == 10'd0);
      end
      default: ;
    endcase
  end

  // A new address phase needs a guaranteed FIFO slot for its data beat.
  assign credit_sum = {1'b0, fifo_cnt} + {{CW{1'b0}}, dphase_q};
  assign credit     = credit_sum < (CW+1)'(FIFO_DEPTH);
  assign fifo_full  = (fifo_cnt == CW'(FIFO_DEPTH));
  assign pop        = (fifo_cnt != '0) && rready;
  assign addr_last  = (iss_cnt == len_q);
  assign push_word  = {(push_err ? '0 : ahb_hrdata), (push_err ? 2'b10 : 2'b00),
                       (push_cnt == len_q)};

  always_comb begin
    next_state = state_q;
    arready    = 1'b0;
    ahb_htrans = HT_IDLE;
    acc        = 1'b0;
    push       = 1'b0;
    push_err   = 1'b0;
    if (state_q == S_ADDR_ONLY || state_q == S_PIPE) begin
      if (credit) ahb_htrans = nonseq_q ? HT_NONSEQ : HT_SEQ;
      else        ahb_htrans = (iss_cnt != 8'd0) ? HT_BUSY : HT_IDLE;
    end
    case (state_q)
      S_IDLE: begin
        arready = 1'b1;
        if (arvalid) next_state = (arsize > MAX_SIZE) ? S_ERR : S_ADDR_ONLY;
      end
      S_ADDR_ONLY: begin
        if (credit && ahb_hready) begin
          acc        = 1'b1;
          next_state = addr_last ? S_DATA_ONLY : S_PIPE;
        end
      end
      S_PIPE: begin
        if (ahb_hresp) begin
          // Pipelined address is dropped; it was never accepted on a wait state.
          push       = ahb_hready;
          push_err   = 1'b1;
          next_state = S_ERR;
        end else if (ahb_hready) begin
          push = 1'b1;
          if (credit) begin
            acc        = 1'b1;
            next_state = addr_last ? S_DATA_ONLY : S_PIPE;
          end else begin
            next_state = S_ADDR_ONLY;
          end
        end
      end
      S_DATA_ONLY: begin
        if (ahb_hresp) begin
          push       = ahb_hready;
          push_err   = 1'b1;
          next_state = S_ERR;
        end else if (ahb_hready) begin
          push = 1'b1;
        end
      end
      S_ERR: begin
        // Finish the erroring data phase first, then synthesise the rest.
        if (dphase_q) begin
          push     = ahb_hready;
          push_err = 1'b1;
        end else if (!fifo_full) begin
          push     = 1'b1;
          push_err = 1'b1;
        end
      end
      S_DRAIN: begin
        if (fifo_cnt == '0) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
    if (push && (push_cnt == len_q)) next_state = S_DRAIN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      id_q     <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      iss_cnt  <= '0;
      push_cnt <= '0;
      dphase_q <= 1'b0;
      nonseq_q <= 1'b1;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      state_q <= next_state;
      if (state_q == S_IDLE && arvalid) begin
        id_q     <= arid;
        addr_q   <= araddr;
        len_q    <= arlen;
        size_q   <= arsize;
        burst_q  <= arburst;
        iss_cnt  <= '0;
        push_cnt <= '0;
        dphase_q <= 1'b0;
        nonseq_q <= 1'b1;
      end else begin
        if (acc) begin
          addr_q   <= next_addr;
          nonseq_q <= next_nonseq;
          iss_cnt  <= iss_cnt + 8'd1;
        end
        if (acc)       dphase_q <= 1'b1;
        else if (push) dphase_q <= 1'b0;
        if (push) push_cnt <= push_cnt + 8'd1;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= push_word;
  end

  assign head       = fifo_mem[rd_ptr];
  assign rvalid     = (fifo_cnt != '0);
  assign rdata      = rvalid ? head[FW-1:3] : '0;
  assign rresp      = rvalid ? head[2:1] : 2'b00;
  assign rlast      = rvalid & head[0];
  assign rid        = id_q;

  assign ahb_haddr  = addr_q;
  assign ahb_hburst = (burst_q == 2'b00) ? 3'b000 : 3'b001;
  assign ahb_hprot  = 4'b0011;
  assign ahb_hsize  = size_q;
  assign ahb_hwrite = 1'b0;
  assign ahb_hwdata = '0;

endmodule

// File: tb/tb_axi4_rd_to_ahb_bridge.sv
// Directed bench: expected AHB transfers and R beats are queued when each
// burst is issued; negedge monitors pop and compare as the DUT presents them.
module tb_axi4_rd_to_ahb_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  arid = '0;
  logic [31:0] araddr = '0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = '0;
  logic [1:0]  arburst = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [3:0]  rid;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b1;
  logic        rlast;
  logic [31:0] ahb_haddr;
  logic [2:0]  ahb_hburst;
  logic [3:0]  ahb_hprot;
  logic [2:0]  ahb_hsize;
  logic [1:0]  ahb_htrans;
  logic        ahb_hwrite;
  logic [63:0] ahb_hwdata;
  logic [63:0] ahb_hrdata = '0;
  logic        ahb_hready = 1'b1;
  logic        ahb_hresp = 1'b0;

  axi4_rd_to_ahb_bridge #(.ADDR_W(32), .DATA_W(64), .ID_W(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready), .rlast(rlast),
    .ahb_haddr(ahb_haddr), .ahb_hburst(ahb_hburst), .ahb_hprot(ahb_hprot),
    .ahb_hsize(ahb_hsize), .ahb_htrans(ahb_htrans), .ahb_hwrite(ahb_hwrite),
    .ahb_hwdata(ahb_hwdata), .ahb_hrdata(ahb_hrdata), .ahb_hready(ahb_hready),
    .ahb_hresp(ahb_hresp)
  );

  always #5 clk = ~clk;

  typedef struct { logic [3:0] id; logic [63:0] data; logic [1:0] resp; logic last; } rbeat_t;
  typedef struct { logic [31:0] addr; logic [1:0] trans; logic [2:0] burst; logic [2:0] size; } ahb_t;

  rbeat_t exp_r[$];
  ahb_t   exp_a[$];
  rbeat_t mon_r;
  ahb_t   mon_a;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_acc    = 0;
  int err_idx  = -1;
  int dp_idx   = 0;
  logic        dp_v = 1'b0;
  logic [31:0] dp_a = '0;
  logic        err_ph = 1'b0;

  function automatic logic [63:0] mem_f(input logic [31:0] a);
    return {~a, a};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_beat(input logic [3:0] id, input logic [63:0] d, input logic [1:0] rs,
                          input logic l);
    rbeat_t b;
    b.id = id; b.data = d; b.resp = rs; b.last = l;
    exp_r.push_back(b);
  endtask

  task automatic exp_ahb(input logic [31:0] a, input logic [1:0] t, input logic [2:0] b,
                         input logic [2:0] s);
    ahb_t e;
    e.addr = a; e.trans = t; e.burst = b; e.size = s;
    exp_a.push_back(e);
  endtask

  task automatic issue(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                       input logic [2:0] sz, input logic [1:0] bu);
    @(posedge clk); #1;
    arid = id; araddr = a; arlen = len; arsize = sz; arburst = bu; arvalid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (arready) break;
    end
    chk("ar_handshake", arready, 1'b1);
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int i;
    i = 0;
    while (i < 400 && !(exp_r.size() == 0 && exp_a.size() == 0 && arready)) begin
      @(negedge clk);
      i++;
    end
    chk(name, (exp_r.size() == 0 && exp_a.size() == 0 && arready), 1'b1);
  endtask

  always @(posedge clk) cyc++;

  // R channel monitor
  always @(negedge clk) begin
    if (!rst && rvalid && rready) begin
      if (exp_r.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL r_unexpected: got beat rdata %0h rresp %0d, expected no beat", rdata, rresp);
      end else begin
        mon_r = exp_r.pop_front();
        chk("rid", rid, mon_r.id);
        chk("rdata", rdata, mon_r.data);
        chk("rresp", rresp, mon_r.resp);
        chk("rlast", rlast, mon_r.last);
      end
    end
  end

  // AHB monitor and slave data-phase tracking
  always @(negedge clk) begin
    if (rst) begin
      dp_v = 1'b0;
      err_ph = 1'b0;
    end else if (ahb_hready) begin
      err_ph = 1'b0;
      if (ahb_htrans[1]) begin
        if (exp_a.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL ahb_unexpected: got transfer at %0h, expected none", ahb_haddr);
        end else begin
          mon_a = exp_a.pop_front();
          chk("haddr", ahb_haddr, mon_a.addr);
          chk("htrans", ahb_htrans, mon_a.trans);
          chk("hburst", ahb_hburst, mon_a.burst);
          chk("hsize", ahb_hsize, mon_a.size);
        end
        dp_v = 1'b1; dp_a = ahb_haddr; dp_idx = n_acc; n_acc++;
      end else begin
        dp_v = 1'b0;
      end
    end
  end

  // AHB slave response drive: two-cycle error on the selected transfer
  always @(posedge clk) begin
    #1;
    if (dp_v && dp_idx == err_idx) begin
      ahb_hrdata = '0;
      ahb_hresp  = 1'b1;
      if (!err_ph) begin
        ahb_hready = 1'b0;
        err_ph = 1'b1;
      end else begin
        ahb_hready = 1'b1;
      end
    end else begin
      ahb_hready = 1'b1;
      ahb_hresp  = 1'b0;
      ahb_hrdata = dp_v ? mem_f(dp_a) : '0;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

  initial begin
    int t0, t1, a0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_arready", arready, 1'b1);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_rlast", rlast, 1'b0);
    chk("rst_rresp", rresp, 2'b00);
    chk("rst_rid", rid, 4'h0);
    chk("rst_htrans", ahb_htrans, 2'b00);
    chk("rst_haddr", ahb_haddr, 32'h0);
    chk("hprot", ahb_hprot, 4'b0011);
    chk("hwrite", ahb_hwrite, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // INCR 4 x 8 bytes, plus first-rvalid latency
    exp_ahb(32'h1000, 2'b10, 3'b001, 3'd3);
    exp_ahb(32'h1008, 2'b11, 3'b001, 3'd3);
    exp_ahb(32'h1010, 2'b11, 3'b001, 3'd3);
    exp_ahb(32'h1018, 2'b11, 3'b001, 3'd3);
    exp_beat(4'h5, mem_f(32'h1000), 2'b00, 1'b0);
    exp_beat(4'h5, mem_f(32'h1008), 2'b00, 1'b0);
    exp_beat(4'h5, mem_f(32'h1010), 2'b00, 1'b0);
    exp_beat(4'h5, mem_f(32'h1018), 2'b00, 1'b1);
    issue(4'h5, 32'h1000, 8'd3, 3'd3, 2'b01);
    t0 = -1; t1 = -1;
    for (int i = 0; i < 30 && t1 < 0; i++) begin
      @(negedge clk);
      if (t0 < 0 && ahb_htrans == 2'b10) t0 = cyc;
      if (rvalid && t1 < 0) t1 = cyc;
    end
    chk("first_rvalid_latency", 64'(t1 - t0), 64'd2);
    wait_drain("drain_incr");

    // WRAP 4 x 8 bytes starting mid-window
    exp_ahb(32'h2018, 2'b10, 3'b001, 3'd3);
    exp_ahb(32'h2000, 2'b10, 3'b001, 3'd3);
    exp_ahb(32'h2008, 2'b11, 3'b001, 3'd3);
    exp_ahb(32'h2010, 2'b11, 3'b001, 3'd3);
    exp_beat(4'h3, mem_f(32'h2018), 2'b00, 1'b0);
    exp_beat(4'h3, mem_f(32'h2000), 2'b00, 1'b0);
    exp_beat(4'h3, mem_f(32'h2008), 2'b00, 1'b0);
    exp_beat(4'h3, mem_f(32'h2010), 2'b00, 1'b1);
    issue(4'h3, 32'h2018, 8'd3, 3'd3, 2'b10);
    wait_drain("drain_wrap");

    // 1KB boundary crossing
    exp_ahb(32'h13F8, 2'b10, 3'b001, 3'd3);
    exp_ahb(32'h1400, 2'b10, 3'b001, 3'd3);
    exp_beat(4'h7, mem_f(32'h13F8), 2'b00, 1'b0);
    exp_beat(4'h7, mem_f(32'h1400), 2'b00, 1'b1);
    issue(4'h7, 32'h13F8, 8'd1, 3'd3, 2'b01);
    wait_drain("drain_1kb");

    // R backpressure on an 8-beat burst
    rready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_ahb(32'h3000 + 32'(i * 8), (i == 0) ? 2'b10 : 2'b11, 3'b001, 3'd3);
      exp_beat(4'hA, mem_f(32'h3000 + 32'(i * 8)), 2'b00, i == 7);
    end
    a0 = n_acc;
    issue(4'hA, 32'h3000, 8'd7, 3'd3, 2'b01);
    repeat (10) @(negedge clk);
    chk("bp_issued_le_depth", (n_acc - a0) <= 4, 1'b1);
    chk("bp_htrans_busy", ahb_htrans, 2'b01);
    chk("bp_rvalid", rvalid, 1'b1);
    chk("bp_rdata_held", rdata, mem_f(32'h3000));
    @(posedge clk); #1;
    rready = 1'b1;
    wait_drain("drain_bp");

    // AHB error on beat 2 of 4
    err_idx = n_acc + 1;
    exp_ahb(32'h4000, 2'b10, 3'b001, 3'd3);
    exp_ahb(32'h4008, 2'b11, 3'b001, 3'd3);
    exp_beat(4'h9, mem_f(32'h4000), 2'b00, 1'b0);
    exp_beat(4'h9, 64'h0, 2'b10, 1'b0);
    exp_beat(4'h9, 64'h0, 2'b10, 1'b0);
    exp_beat(4'h9, 64'h0, 2'b10, 1'b1);
    issue(4'h9, 32'h4000, 8'd3, 3'd3, 2'b01);
    wait_drain("drain_err");
    repeat (5) @(negedge clk);
    err_idx = -1;

    // FIXED, narrow 4-byte beats
    for (int i = 0; i < 3; i++) begin
      exp_ahb(32'h7000, 2'b10, 3'b000, 3'd2);
      exp_beat(4'h2, mem_f(32'h7000), 2'b00, i == 2);
    end
    issue(4'h2, 32'h7000, 8'd2, 3'd2, 2'b00);
    wait_drain("drain_fixed");

    // Oversize request: no AHB traffic, all beats SLVERR
    exp_beat(4'h4, 64'h0, 2'b10, 1'b0);
    exp_beat(4'h4, 64'h0, 2'b10, 1'b1);
    issue(4'h4, 32'h8000, 8'd1, 3'd4, 2'b01);
    wait_drain("drain_oversize");

    // Single beat
    exp_ahb(32'h9000, 2'b10, 3'b001, 3'd3);
    exp_beat(4'h1, mem_f(32'h9000), 2'b00, 1'b1);
    issue(4'h1, 32'h9000, 8'd0, 3'd3, 2'b01);
    wait_drain("drain_single");

    // Reset mid-burst
    rready = 1'b0;
    for (int i = 0; i < 8; i++)
      exp_ahb(32'h5000 + 32'(i * 8), (i == 0) ? 2'b10 : 2'b11, 3'b001, 3'd3);
    issue(4'hC, 32'h5000, 8'd7, 3'd3, 2'b01);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_a.delete();
    @(negedge clk);
    chk("midrst_htrans", ahb_htrans, 2'b00);
    chk("midrst_rvalid", rvalid, 1'b0);
    chk("midrst_arready", arready, 1'b1);
    repeat (3) @(negedge clk);
    chk("midrst_no_beats", rvalid, 1'b0);
    rready = 1'b1;

    exp_ahb(32'h6000, 2'b10, 3'b001, 3'd3);
    exp_ahb(32'h6008, 2'b11, 3'b001, 3'd3);
    exp_beat(4'h6, mem_f(32'h6000), 2'b00, 1'b0);
    exp_beat(4'h6, mem_f(32'h6008), 2'b00, 1'b1);
    issue(4'h6, 32'h6000, 8'd1, 3'd3, 2'b01);
    wait_drain("drain_after_rst");
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
